// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master (MSB first, active-low select). After each byte
// it releases ss_l and issues one extra sclk pulse so the slave commits its byte.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss_l
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SCK_H    = 3'd2,
    SCK_L    = 3'd3,
    DESEL    = 3'd4,
    COMMIT_H = 3'd5,
    COMMIT_L = 3'd6
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_r, state_s;
  logic [7:0] div_r, div_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  logic [7:0] tx_sr_r, tx_sr_s;
  logic [7:0] rx_sr_r, rx_sr_s;
  logic [7:0] rx_data_s;
  logic       sclk_s, mosi_s, ss_l_s, busy_s, done_s;
  logic       phase_end_s;

  assign phase_end_s = (div_r == DIV_LAST);

  // Next-state and next-output logic; every phase is one full divider period.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_idx_s = bit_idx_r;
    tx_sr_s   = tx_sr_r;
    rx_sr_s   = rx_sr_r;
    rx_data_s = rx_data;
    sclk_s    = sclk;
    mosi_s    = mosi;
    ss_l_s    = ss_l;
    busy_s    = busy;
    done_s    = 1'b0;

    if (state_r == IDLE) begin
      div_s = 8'd0;
    end else if (phase_end_s) begin
      div_s = 8'd0;
    end else begin
      div_s = div_r + 8'd1;
    end

    case (state_r)
      IDLE: begin
        sclk_s = 1'b0;
        ss_l_s = 1'b1;
        mosi_s = 1'b0;
        if (start) begin
          tx_sr_s   = tx_data;
          bit_idx_s = 3'd7;
          busy_s    = 1'b1;
          ss_l_s    = 1'b0;
          mosi_s    = tx_data[7];
          state_s   = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (phase_end_s) begin
          sclk_s  = 1'b1;
          state_s = SCK_H;
        end else begin
          state_s = SETUP;
        end
      end
      SCK_H: begin
        // miso is sampled here, while sclk is still high; the slave only moves it after the fall.
        if (phase_end_s) begin
          rx_sr_s = {rx_sr_r[6:0], miso};
          sclk_s  = 1'b0;
          tx_sr_s = {tx_sr_r[6:0], 1'b0};
          mosi_s  = (bit_idx_r == 3'd0) ? 1'b0 : tx_sr_r[6];
          state_s = SCK_L;
        end else begin
          state_s = SCK_H;
        end
      end
      SCK_L: begin
        if (!phase_end_s) begin
          state_s = SCK_L;
        end else if (bit_idx_r != 3'd0) begin
          bit_idx_s = bit_idx_r - 3'd1;
          sclk_s    = 1'b1;
          state_s   = SCK_H;
        end else begin
          ss_l_s  = 1'b1;
          state_s = DESEL;
        end
      end
      DESEL: begin
        if (phase_end_s) begin
          sclk_s  = 1'b1;
          state_s = COMMIT_H;
        end else begin
          state_s = DESEL;
        end
      end
      COMMIT_H: begin
        if (phase_end_s) begin
          sclk_s  = 1'b0;
          state_s = COMMIT_L;
        end else begin
          state_s = COMMIT_H;
        end
      end
      COMMIT_L: begin
        if (phase_end_s) begin
          rx_data_s = rx_sr_r;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          state_s   = IDLE;
        end else begin
          state_s = COMMIT_L;
        end
      end
      default: begin
        state_s   = IDLE;
        div_s     = 8'd0;
        bit_idx_s = 3'd0;
        sclk_s    = 1'b0;
        ss_l_s    = 1'b1;
        mosi_s    = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r   <= IDLE;
      div_r     <= 8'd0;
      bit_idx_r <= 3'd0;
      tx_sr_r   <= 8'h00;
      rx_sr_r   <= 8'h00;
      rx_data   <= 8'h00;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss_l      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_idx_r <= bit_idx_s;
      tx_sr_r   <= tx_sr_s;
      rx_sr_r   <= rx_sr_s;
      rx_data   <= rx_data_s;
      sclk      <= sclk_s;
      mosi      <= mosi_s;
      ss_l      <= ss_l_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI master (mode 0: CPOL=0, CPHA=0, MSB first, active-low slave select) driving the board's SPI bus from the CPLD system clock. It is the initiating end for the team's SPI slave blocks. After each byte it deasserts `ss_l` and issues one extra "commit" `sclk` pulse with `ss_l` high, because the slave latches its received byte and loads its next transmit byte on a falling `sclk` edge while deselected. A host-side start/busy/done handshake frames each transfer.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles. Legal range 2..255; the bench rejects other values.
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `rst_l` in 1: reset, asynchronous and active-low.
- `start` in 1: request a transfer; accepted only on a rising `clk` edge where `busy`=0.
- `tx_data` in 8: byte to send; captured when `start` is accepted.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse; `rx_data` is valid from this cycle on.
- `rx_data` out 8: last byte received on `miso`; holds until the next `done`.
- `sclk` out 1: SPI clock; idles at 0.
- `mosi` out 1: serial data out; 0 whenever not shifting.
- `miso` in 1: serial data in; may be high-Z while `ss_l`=1 and is never sampled then.
- `ss_l` out 1: slave select, active-low.

## Operation
- All outputs are registered. Reset values: `sclk`=0, `ss_l`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=8'h00. Internally, state=IDLE, divider=0 and bit counter=0.
- A `CLK_DIV`-cycle divider times every phase. A phase ends at the `clk` edge where the divider equals `CLK_DIV`-1; the divider then returns to 0.
- Internal state is a 3-bit bit index (7 down to 0), an 8-bit tx shift register and an 8-bit rx shift register.
- States:
  - IDLE: `ss_l`=1, `sclk`=0, `mosi`=0. If `start`=1, latch `tx_data`, set `busy`=1, drive `ss_l`=0 and `mosi`=`tx_data[7]`, then go to SETUP.
  - SETUP: lasts one phase; `ss_l` low, `mosi` stable; go to SCK_H with `sclk`=1.
  - SCK_H: lasts one phase. At the end, shift `miso` into the rx register LSB, drive `sclk`=0, and shift `mosi` to the next bit. `mosi` is 0 after bit 0. Go to SCK_L.
  - SCK_L: lasts one phase. If bits remain, drive `sclk`=1 and go to SCK_H. After bit 0, drive `ss_l`=1 and go to DESEL.
  - DESEL: lasts one phase; `ss_l`=1, `sclk`=0. Drive `sclk`=1 and go to COMMIT_H.
  - COMMIT_H: lasts one phase; `sclk`=1, `ss_l`=1, `miso` ignored. Drive `sclk`=0 (this falling edge is the slave's commit edge) and go to COMMIT_L.
  - COMMIT_L: lasts one phase. At the end, load `rx_data` from the rx register, set `done`=1 and `busy`=0, then go to IDLE.
- `miso` is sampled at the `clk` edge that ends SCK_H, just before `sclk` falls. The slave changes `miso` only after `sclk` falls, so no synchronizer is required.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` asserted in the `done` cycle is accepted, giving back-to-back transfers separated by exactly one IDLE cycle.
- `tx_data` changes after acceptance have no effect on the current transfer.
- Reset mid-transfer forces all reset values immediately (asynchronously). The slave is left uncommitted, and `done` is never pulsed for the aborted byte.

## Timing
- `start` accepted at edge N: `ss_l` falls at N, and the first `sclk` rise is at N+`CLK_DIV`.
- Bit k (k=7..0) has `sclk` high during [N+(1+2(7-k))·`CLK_DIV`, N+(2+2(7-k))·`CLK_DIV`).
- `ss_l` rises at N+17·`CLK_DIV`, so it is low for 17·`CLK_DIV` cycles.
- Commit pulse: `sclk` is high during [N+18·`CLK_DIV`, N+19·`CLK_DIV`).
- `done`=1 and `busy`=0 from edge N+20·`CLK_DIV` for one cycle. Total latency is 20·`CLK_DIV` cycles; `rx_data` updates at the same edge.
- Each transfer produces exactly 9 `sclk` rising edges: 8 data edges and 1 commit edge.
- `mosi` is valid at least `CLK_DIV` cycles before every data `sclk` rise and changes only on `sclk`-falling `clk` edges.

## Test plan
- Reset: with `rst_l` held low mid-activity, check `sclk`=0, `ss_l`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=00.
- `CLK_DIV`=4, `tx_data`=A5, a slave-side behavioral model returns 3C:
  - `mosi` bits are 1,0,1,0,0,1,0,1 at each `sclk` rise.
  - `ss_l` is low for 68 cycles.
  - There are 9 `sclk` rises.
  - `done` fires at start+80 and `rx_data`=3C.
- Slave model loaded with 5A is committed only by the commit pulse. Send 81 twice: the slave's out register reads 81 after the first transfer, and the second transfer returns 5A.
- `start` pulsed at cycles 10 and 30 of an active transfer is ignored (`done` pulses once). `start` held high through `done` launches a second transfer whose `ss_l` falls one cycle after `done`.
- `rst_l` asserted during bit 4 gives immediate reset values. A following `start` with `tx_data`=FF completes normally with `mosi` all ones.
- `CLK_DIV`=2, `tx_data`=00, `miso` tied 1: `rx_data`=FF and `done` fires at start+40.
